// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU result + N/Z/C/V flags into a 2-entry valid/ready FIFO.
// Latency 1 cycle push->out_valid; in_ready drops only when both entries are full.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_result_stage #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [7:0]  ARITH_MASK = 8'b1100_0000,
    parameter logic [7:0]  SUB_MASK   = 8'b0100_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_func,
    input  logic             in_carry,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_func,
    output logic [3:0]       out_flags,
    input  logic             sticky_clr,
    output logic             sticky_v
);
    logic [WIDTH-1:0] mem_result [2];
    logic [2:0]       mem_func   [2];
    logic [3:0]       mem_flags  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic             arith;
    logic             msb;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    assign in_ready  = ~rst & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flags are resolved at capture time so the entry carries everything downstream needs.
    assign arith  = ARITH_MASK[in_func];
    assign msb    = in_result[WIDTH-1];
    assign flag_n = msb;
    assign flag_z = (in_result == '0);
    assign flag_c = arith & in_carry;
    assign flag_v = arith & (in_a_msb ^ msb) & ((in_b_msb ^ SUB_MASK[in_func]) ^ msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_result[i] <= '0;
                mem_func[i]   <= '0;
                mem_flags[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= in_result;
                mem_func[wr_ptr]   <= in_func;
                mem_flags[wr_ptr]  <= {flag_n, flag_z, flag_c, flag_v};
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_result = mem_result[rd_ptr];
    assign out_func   = mem_func[rd_ptr];
    assign out_flags  = mem_flags[rd_ptr];

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    // A set on the same edge as a clear takes priority so no overflow is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (pop && mem_flags[rd_ptr][0]) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_v          = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: random and directed stimulus against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_result_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [2:0] in_func;
    logic       in_carry;
    logic       in_a_msb;
    logic       in_b_msb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_func;
    logic [3:0] out_flags;
    logic       sticky_clr;
    logic       sticky_v;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] r;
        logic [2:0] f;
        logic [3:0] fl;
    } ent_t;

    ent_t q[$];
    logic m_sticky = 1'b0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_func(in_func),
        .in_carry(in_carry), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_func(out_func), .out_flags(out_flags),
        .sticky_clr(sticky_clr), .sticky_v(sticky_v)
    );

    // Flags from the arithmetic meaning: add overflows when same-sign operands give a
    // different-sign result; subtract when different-sign operands flip A's sign.
    function automatic logic [3:0] ref_flags(input logic [7:0] r, input logic [2:0] f,
                                             input logic c, input logic a, input logic b);
        logic n, z, cc, v;
        n  = r[7];
        z  = (r == 8'd0);
        cc = 1'b0;
        v  = 1'b0;
        if (f == 3'b111) begin
            cc = c;
            v  = (a == b) && (n != a);
        end else if (f == 3'b110) begin
            cc = c;
            v  = (a != b) && (n != a);
        end
        return {n, z, cc, v};
    endfunction

    // Applies one cycle of stimulus and advances the model; no checking here.
    task automatic step(input logic iv, input logic [7:0] r, input logic [2:0] f,
                        input logic c, input logic a, input logic b,
                        input logic ordy, input logic sclr);
        bit   push, pop;
        ent_t e;
        in_valid   = iv;
        in_result  = r;
        in_func    = f;
        in_carry   = c;
        in_a_msb   = a;
        in_b_msb   = b;
        out_ready  = ordy;
        sticky_clr = sclr;
        push = iv && (q.size() < 2);
        pop  = (q.size() != 0) && ordy;
`ifdef ALU_STICKY_OVF_EN
        if (pop && q[0].fl[0]) m_sticky = 1'b1;
        else if (sclr)         m_sticky = 1'b0;
`endif
        e.r  = r;
        e.f  = f;
        e.fl = ref_flags(r, f, c, a, b);
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
            if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        end
        rst = 1'b0;
        q.delete();
        m_sticky = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        if (out_flags !== 4'b0000) begin failures++; $display("FAIL rel_flags got=%b exp=0000", out_flags); end
        if (out_result !== 8'h00) begin failures++; $display("FAIL rel_result got=%h exp=00", out_result); end
        if (sticky_v !== 1'b0) begin failures++; $display("FAIL rel_sticky got=%b exp=0", sticky_v); end
    endtask

    task automatic test_flags;
        step(1, 8'h00, 3'b111, 1, 1, 1, 0, 0);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        if (out_flags !== 4'b0111) begin failures++; $display("FAIL add_flags got=%b exp=0111", out_flags); end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        step(1, 8'h80, 3'b000, 1, 0, 0, 0, 0);
        checks += 2;
        if (out_flags !== 4'b1000) begin failures++; $display("FAIL logic_flags got=%b exp=1000", out_flags); end
        if (out_func !== 3'b000) begin failures++; $display("FAIL logic_func got=%b exp=000", out_func); end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 24; i++) begin
            step(1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
            checks += 3;
            if (out_result !== q[0].r) begin failures++; $display("FAIL rnd_result got=%h exp=%h", out_result, q[0].r); end
            if (out_func !== q[0].f) begin failures++; $display("FAIL rnd_func got=%b exp=%b", out_func, q[0].f); end
            if (out_flags !== q[0].fl) begin failures++; $display("FAIL rnd_flags f=%b got=%b exp=%b", q[0].f, out_flags, q[0].fl); end
            step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_backpressure;
        step(1, 8'h11, 3'b000, 0, 0, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        step(1, 8'h22, 3'b000, 0, 0, 0, 0, 0);
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
        if (out_result !== 8'h11) begin failures++; $display("FAIL bp_head got=%h exp=11", out_result); end
        repeat (3) begin
            step(1, 8'h33, 3'b000, 0, 0, 0, 0, 0);
            checks += 2;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
            if (out_result !== 8'h11) begin failures++; $display("FAIL bp_hold got=%h exp=11", out_result); end
        end
        step(1, 8'h33, 3'b000, 0, 0, 0, 1, 0);
        checks++;
        if (out_result !== 8'h22) begin failures++; $display("FAIL bp_second got=%h exp=22", out_result); end
        step(1, 8'h33, 3'b000, 0, 0, 0, 1, 0);
        checks++;
        if (out_result !== 8'h33) begin failures++; $display("FAIL bp_third got=%h exp=33", out_result); end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 3'b000, 0, 0, 0, 1, 0);
            checks += 3;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, out_valid); end
            if (out_result !== 8'(i)) begin failures++; $display("FAIL b2b_data got=%h exp=%h", out_result, 8'(i)); end
        end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom);
            step($urandom_range(0, 3) != 0, 8'($urandom), f, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            checks += 3;
            if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rr_ready got=%b size=%0d", in_ready, q.size()); end
            if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rr_valid got=%b size=%0d", out_valid, q.size()); end
            if (sticky_v !== m_sticky) begin failures++; $display("FAIL rr_sticky got=%b exp=%b", sticky_v, m_sticky); end
            if (q.size() != 0) begin
                checks++;
                if ({out_result, out_func, out_flags} !== {q[0].r, q[0].f, q[0].fl})
                begin
                    failures++;
                    $display("FAIL rr_head got=%h/%b/%b exp=%h/%b/%b", out_result, out_func, out_flags, q[0].r, q[0].f, q[0].fl);
                end
            end
        end
        while (q.size() != 0) step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
    endtask

    task automatic test_sticky;
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 1);
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        step(1, 8'h80, 3'b110, 0, 0, 1, 0, 0);
        checks++;
        if (out_flags !== 4'b1001) begin failures++; $display("FAIL st_flags got=%b exp=1001", out_flags); end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        repeat (2) begin
            checks++;
`ifdef ALU_STICKY_OVF_EN
            if (sticky_v !== 1'b1) begin failures++; $display("FAIL st_set got=%b exp=1", sticky_v); end
`else
            if (sticky_v !== 1'b0) begin failures++; $display("FAIL st_off got=%b exp=0", sticky_v); end
`endif
            step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        end
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 1);
        checks++;
        if (sticky_v !== 1'b0) begin failures++; $display("FAIL st_clr got=%b exp=0", sticky_v); end
        step(1, 8'h80, 3'b110, 0, 0, 1, 0, 0);
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 1);
        checks++;
        if (sticky_v !== m_sticky) begin failures++; $display("FAIL st_setwins got=%b exp=%b", sticky_v, m_sticky); end
    endtask

    task automatic test_mid_reset;
        step(1, 8'h5A, 3'b111, 1, 0, 0, 0, 0);
        step(1, 8'hA5, 3'b110, 1, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_ready got=%b exp=0", in_ready); end
        if (out_result !== 8'h00) begin failures++; $display("FAIL mr_result got=%h exp=00", out_result); end
        if ({out_func, out_flags} !== 7'd0) begin failures++; $display("FAIL mr_funcflags got=%b exp=0", {out_func, out_flags}); end
        rst = 1'b0;
        q.delete();
        m_sticky = 1'b0;
        step(0, 8'h00, 3'b000, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_empty got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_result = 8'h00; in_func = 3'b000; in_carry = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        test_reset();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_sticky();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
